// File: rtl/mixed_precision_csr_unit.sv
// Mixed-precision CSR block: cycle/format/skip CSRs with controller-driven cycle updates.
// Optional sequence counter at 0x00C enabled by `define MPC_SEQ_COUNTER_EN.
package riscv_defines;
    localparam int unsigned NBITS_MIXED_CYCLES = 3;
    localparam int unsigned NBITS_MAX_KER      = 8;

    typedef enum logic [2:0] {
        MIXED_NONE  = 3'd0,
        MIXED_2x4   = 3'd1,
        MIXED_4x8   = 3'd2,
        MIXED_8x16  = 3'd3,
        MIXED_2x8   = 3'd4,
        MIXED_4x16  = 3'd5,
        MIXED_2x16  = 3'd6,
        MIXED_RSVD  = 3'd7
    } ivec_mode_fmt;
endpackage

module mixed_precision_csr_unit
    import riscv_defines::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          csr_we_i,
    input  logic [11:0]                   csr_addr_i,
    input  logic [31:0]                   csr_wdata_i,
    output logic [31:0]                   csr_rdata_o,
    input  logic                          ctrl_we_i,
    input  logic [NBITS_MIXED_CYCLES-1:0] ctrl_next_cycle_i,
    output logic [NBITS_MIXED_CYCLES-1:0] current_cycle_o,
    output ivec_mode_fmt                  ivec_fmt_o,
    output logic [NBITS_MAX_KER-1:0]      skip_size_o,
    output logic                          wrap_o
);
    localparam int unsigned CW = NBITS_MIXED_CYCLES;
    localparam int unsigned SW = NBITS_MAX_KER;
    localparam int unsigned FW = $bits(ivec_mode_fmt);

    localparam logic [11:0] ADDR_CNT  = 12'h00C;
    localparam logic [11:0] ADDR_CYC  = 12'h00D;
    localparam logic [11:0] ADDR_FMT  = 12'h00E;
    localparam logic [11:0] ADDR_SKIP = 12'h00F;

    // Highest legal cycle index for each packing format.
    function automatic logic [CW-1:0] cycle_max(input ivec_mode_fmt f);
        case (f)
            MIXED_2x4, MIXED_4x8, MIXED_8x16: return CW'(1);
            MIXED_2x8, MIXED_4x16:            return CW'(3);
            MIXED_2x16:                       return CW'(7);
            default:                          return '0;
        endcase
    endfunction

    logic [CW-1:0] cycle_q, cycle_d;
    ivec_mode_fmt  fmt_q, fmt_d;
    logic [SW-1:0] skip_q, skip_d;
    logic          wrap_q, wrap_d;

    logic          sw_cyc, sw_fmt, sw_skip;
    logic [CW-1:0] max_c;
    logic [CW-1:0] ctrl_cycle;

    assign sw_cyc     = csr_we_i && (csr_addr_i == ADDR_CYC);
    assign sw_fmt     = csr_we_i && (csr_addr_i == ADDR_FMT);
    assign sw_skip    = csr_we_i && (csr_addr_i == ADDR_SKIP);
    assign max_c      = cycle_max(fmt_q);
    assign ctrl_cycle = ctrl_next_cycle_i & max_c;

    // Software writes to cycle/format take priority over the controller.
    always_comb begin
        cycle_d = cycle_q;
        fmt_d   = fmt_q;
        skip_d  = skip_q;
        wrap_d  = 1'b0;
        if (sw_fmt) begin
            fmt_d   = ivec_mode_fmt'(csr_wdata_i[FW-1:0]);
            cycle_d = '0;
        end else if (sw_cyc) begin
            cycle_d = csr_wdata_i[CW-1:0] & max_c;
        end else if (ctrl_we_i) begin
            cycle_d = ctrl_cycle;
            wrap_d  = (max_c != '0) && (cycle_q == max_c) && (ctrl_cycle == '0);
        end
        if (sw_skip) begin
            skip_d = csr_wdata_i[SW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q <= '0;
            fmt_q   <= MIXED_NONE;
            skip_q  <= SW'(1);
            wrap_q  <= 1'b0;
        end else begin
            cycle_q <= cycle_d;
            fmt_q   <= fmt_d;
            skip_q  <= skip_d;
            wrap_q  <= wrap_d;
        end
    end

`ifdef MPC_SEQ_COUNTER_EN
    logic [31:0] cnt_q, cnt_d;

    // Counts completed sequences; a software write overrides the increment.
    always_comb begin
        cnt_d = cnt_q;
        if (csr_we_i && (csr_addr_i == ADDR_CNT)) begin
            cnt_d = csr_wdata_i;
        end else if (wrap_q) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_wdata;
    assign unused_wdata = ^csr_wdata_i[31:SW];
`endif

    always_comb begin
        csr_rdata_o = '0;
        case (csr_addr_i)
            ADDR_CYC:  csr_rdata_o = 32'(cycle_q);
            ADDR_FMT:  csr_rdata_o = 32'(fmt_q);
            ADDR_SKIP: csr_rdata_o = 32'(skip_q);
`ifdef MPC_SEQ_COUNTER_EN
            ADDR_CNT:  csr_rdata_o = cnt_q;
`endif
            default:   csr_rdata_o = '0;
        endcase
    end

    assign current_cycle_o = cycle_q;
    assign ivec_fmt_o      = fmt_q;
    assign skip_size_o     = skip_q;
    assign wrap_o          = wrap_q;

endmodule

// File: tb/tb_mixed_precision_csr_unit.sv
// Directed bench for mixed_precision_csr_unit with a cycle-level reference model.
module tb_mixed_precision_csr_unit;
    import riscv_defines::*;

    logic                          clk;
    logic                          rst_n;
    logic                          csr_we_i;
    logic [11:0]                   csr_addr_i;
    logic [31:0]                   csr_wdata_i;
    logic [31:0]                   csr_rdata_o;
    logic                          ctrl_we_i;
    logic [NBITS_MIXED_CYCLES-1:0] ctrl_next_cycle_i;
    logic [NBITS_MIXED_CYCLES-1:0] current_cycle_o;
    ivec_mode_fmt                  ivec_fmt_o;
    logic [NBITS_MAX_KER-1:0]      skip_size_o;
    logic                          wrap_o;

    mixed_precision_csr_unit dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .csr_we_i          (csr_we_i),
        .csr_addr_i        (csr_addr_i),
        .csr_wdata_i       (csr_wdata_i),
        .csr_rdata_o       (csr_rdata_o),
        .ctrl_we_i         (ctrl_we_i),
        .ctrl_next_cycle_i (ctrl_next_cycle_i),
        .current_cycle_o   (current_cycle_o),
        .ivec_fmt_o        (ivec_fmt_o),
        .skip_size_o       (skip_size_o),
        .wrap_o            (wrap_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit run_cmp  = 1'b0;
    int wraps    = 0;

    // Reference state
    int          max_tab [8];
    int          m_cyc, m_fmt, m_skip;
    bit          m_wrap;
    logic [31:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h00D: return 32'(m_cyc);
            12'h00E: return 32'(m_fmt);
            12'h00F: return 32'(m_skip);
`ifdef MPC_SEQ_COUNTER_EN
            12'h00C: return m_cnt;
`endif
            default: return 32'd0;
        endcase
    endfunction

    // Model: applies the CSR rules to the inputs present at each rising edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc  = 0;
            m_fmt  = 0;
            m_skip = 1;
            m_wrap = 1'b0;
            m_cnt  = 32'd0;
        end else begin
            int mx;
            int nv;
            bit nw;
            mx = max_tab[m_fmt];
            nw = 1'b0;
            if (csr_we_i && csr_addr_i == 12'h00E) begin
                m_fmt = int'(csr_wdata_i[2:0]);
                m_cyc = 0;
            end else if (csr_we_i && csr_addr_i == 12'h00D) begin
                m_cyc = int'(csr_wdata_i[7:0]) & mx;
            end else if (ctrl_we_i) begin
                nv = int'(ctrl_next_cycle_i) & mx;
                nw = (mx > 0) && (m_cyc == mx) && (nv == 0);
                m_cyc = nv;
            end
            if (csr_we_i && csr_addr_i == 12'h00F)
                m_skip = int'(csr_wdata_i) & ((1 << NBITS_MAX_KER) - 1);
            if (csr_we_i && csr_addr_i == 12'h00C) m_cnt = csr_wdata_i;
            else if (m_wrap) m_cnt = m_cnt + 32'd1;
            m_wrap = nw;
        end
    end

    always @(negedge clk) begin
        if (rst_n && run_cmp) begin
            chk("cmp_cycle", 32'(current_cycle_o), 32'(m_cyc));
            chk("cmp_fmt",   32'(ivec_fmt_o),      32'(m_fmt));
            chk("cmp_skip",  32'(skip_size_o),     32'(m_skip));
            chk("cmp_wrap",  32'(wrap_o),          32'(m_wrap));
            chk("cmp_rdata", csr_rdata_o,          m_read(csr_addr_i));
            if (wrap_o) wraps++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_we_i    = 1'b1;
        csr_addr_i  = a;
        csr_wdata_i = d;
        tick();
        csr_we_i    = 1'b0;
    endtask

    task automatic ctl(input int nv);
        ctrl_we_i         = 1'b1;
        ctrl_next_cycle_i = NBITS_MIXED_CYCLES'(nv);
        tick();
        ctrl_we_i         = 1'b0;
    endtask

    task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
        csr_addr_i = a;
        #1;
        chk(name, csr_rdata_o, exp);
    endtask

    initial begin
        max_tab[MIXED_NONE] = 0; max_tab[MIXED_2x4]  = 1; max_tab[MIXED_4x8]  = 1;
        max_tab[MIXED_8x16] = 1; max_tab[MIXED_2x8]  = 3; max_tab[MIXED_4x16] = 3;
        max_tab[MIXED_2x16] = 7; max_tab[MIXED_RSVD] = 0;
        rst_n = 1'b0; csr_we_i = 1'b0; csr_addr_i = 12'h00F; csr_wdata_i = '0;
        ctrl_we_i = 1'b0; ctrl_next_cycle_i = '0;
        #23;
        chk("rst_cycle", 32'(current_cycle_o), 32'd0);
        chk("rst_fmt",   32'(ivec_fmt_o),      32'd0);
        chk("rst_skip",  32'(skip_size_o),     32'd1);
        chk("rst_wrap",  32'(wrap_o),          32'd0);
        chk("rst_rd_skip", csr_rdata_o,        32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_cmp = 1'b1;
        tick();

        // 2x4 sequence: 1,0,1,0 with two wraps
        wr(12'h00E, 32'(MIXED_2x4));
        rd("rd_fmt_2x4", 12'h00E, 32'd1);
        wraps = 0;
        ctrl_we_i = 1'b1;
        ctrl_next_cycle_i = 3'd1; tick(); chk("seq_c1", 32'(current_cycle_o), 1); chk("seq_w1", 32'(wrap_o), 0);
        ctrl_next_cycle_i = 3'd0; tick(); chk("seq_c2", 32'(current_cycle_o), 0); chk("seq_w2", 32'(wrap_o), 1);
        ctrl_next_cycle_i = 3'd1; tick(); chk("seq_c3", 32'(current_cycle_o), 1); chk("seq_w3", 32'(wrap_o), 0);
        ctrl_next_cycle_i = 3'd0; tick(); chk("seq_c4", 32'(current_cycle_o), 0); chk("seq_w4", 32'(wrap_o), 1);
        ctrl_we_i = 1'b0;
        tick();
        chk("seq_wrap_pulse", 32'(wrap_o), 0);
        chk("seq_wrap_count", 32'(wraps), 2);

        // 2x16: masked software write, then wrap from 7
        wr(12'h00E, 32'(MIXED_2x16));
        wr(12'h00D, 32'h1F);
        chk("2x16_cyc7", 32'(current_cycle_o), 7);
        ctl(0);
        chk("2x16_cyc0", 32'(current_cycle_o), 0);
        chk("2x16_wrap", 32'(wrap_o), 1);
        tick();
        chk("2x16_wrap_off", 32'(wrap_o), 0);

        // 2x8: software and controller collide
        wr(12'h00E, 32'(MIXED_2x8));
        wr(12'h00D, 32'd2);
        csr_we_i = 1'b1; csr_addr_i = 12'h00D; csr_wdata_i = 32'd1;
        ctl(3);
        csr_we_i = 1'b0;
        chk("coll_cyc", 32'(current_cycle_o), 1);
        chk("coll_wrap", 32'(wrap_o), 0);
        wr(12'h00D, 32'd3);
        csr_we_i = 1'b1; csr_addr_i = 12'h00D; csr_wdata_i = 32'd3;
        ctl(0);
        csr_we_i = 1'b0;
        chk("coll_nowrap", 32'(wrap_o), 0);
        chk("coll_cyc3", 32'(current_cycle_o), 3);

        // Format change clears cycle
        wr(12'h00E, 32'(MIXED_4x16));
        wr(12'h00D, 32'd3);
        chk("4x16_cyc3", 32'(current_cycle_o), 3);
        wr(12'h00E, 32'(MIXED_2x4));
        chk("fmtchg_cyc", 32'(current_cycle_o), 0);
        chk("fmtchg_fmt", 32'(ivec_fmt_o), 32'(MIXED_2x4));
        rd("fmtchg_rd", 12'h00E, 32'(MIXED_2x4));

        // Skip size plus concurrent controller update; masking of next value
        wr(12'h00F, 32'hFFFF_FFA5);
        chk("skip_a5", 32'(skip_size_o), 32'hA5);
        csr_we_i = 1'b1; csr_addr_i = 12'h00F; csr_wdata_i = 32'd0;
        ctl(7);
        csr_we_i = 1'b0;
        chk("skip_0", 32'(skip_size_o), 0);
        chk("skip_ctrl_cyc", 32'(current_cycle_o), 1);

        // Non-mixed and reserved formats pin cycle at 0
        wr(12'h00E, 32'd0);
        ctl(5);
        chk("nonmix_cyc", 32'(current_cycle_o), 0);
        chk("nonmix_wrap", 32'(wrap_o), 0);
        wr(12'h00E, 32'd7);
        wr(12'h00D, 32'd5);
        ctl(0);
        chk("rsvd_cyc", 32'(current_cycle_o), 0);

        // Unmapped address
        wr(12'h010, 32'hDEAD_BEEF);
        rd("unmapped_rd", 12'h010, 32'd0);

        // Sequence counter
        wr(12'h00C, 32'hFFFF_FFFF);
        wr(12'h00E, 32'(MIXED_2x4));
        ctl(1);
        ctl(0);
        tick();
        tick();
`ifdef MPC_SEQ_COUNTER_EN
        rd("cnt_wrap_rd", 12'h00C, 32'd0);
`else
        rd("cnt_absent_rd", 12'h00C, 32'd0);
`endif

        // Asynchronous reset mid-sequence
        wr(12'h00E, 32'(MIXED_2x16));
        wr(12'h00F, 32'd9);
        wr(12'h00D, 32'd5);
        chk("pre_rst_cyc", 32'(current_cycle_o), 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cycle", 32'(current_cycle_o), 0);
        chk("arst_skip",  32'(skip_size_o),     1);
        chk("arst_wrap",  32'(wrap_o),          0);
        chk("arst_fmt",   32'(ivec_fmt_o),      0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        wr(12'h00E, 32'(MIXED_2x8));
        ctl(1);
        chk("post_rst_cyc", 32'(current_cycle_o), 1);
        chk("post_rst_wrap", 32'(wrap_o), 0);
        tick();
        run_cmp = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
